// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 4-to-1 mux.
// Grants are held while the owner keeps requesting, bounded by MAX_HOLD when others wait.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_valid
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  logic [3:0] others;
  logic [2:0] pick_all;
  logic [2:0] pick_oth;

  // Returns {found, index}: first set bit of vec searching upward from last+1, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_comb begin
    others   = i_req & ~gnt_q;
    pick_all = rr_pick(i_req, ptr_q);
    pick_oth = rr_pick(others, ptr_q);

    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d    = BUSY;
          ptr_d      = pick_all[1:0];
          hold_cnt_d = 8'd1;
          gnt_d      = onehot(pick_all[1:0]);
          sel_d      = pick_all[1:0];
          valid_d    = 1'b1;
        end else begin
          hold_cnt_d = '0;
          gnt_d      = '0;
          sel_d      = '0;
          valid_d    = 1'b0;
        end
      end
      BUSY: begin
        if (!i_req[sel_q]) begin
          if (pick_oth[2]) begin
            ptr_d      = pick_oth[1:0];
            hold_cnt_d = 8'd1;
            gnt_d      = onehot(pick_oth[1:0]);
            sel_d      = pick_oth[1:0];
          end else begin
            // Owner gone and nobody waiting: ptr keeps the last owner for fairness.
            state_d    = IDLE;
            hold_cnt_d = '0;
            gnt_d      = '0;
            sel_d      = '0;
            valid_d    = 1'b0;
          end
        end else if ((hold_cnt_q == HOLD_LIMIT) && pick_oth[2]) begin
          ptr_d      = pick_oth[1:0];
          hold_cnt_d = 8'd1;
          gnt_d      = onehot(pick_oth[1:0]);
          sel_d      = pick_oth[1:0];
        end else if (hold_cnt_q < HOLD_LIMIT) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_sel   = sel_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus randomized traffic against an owner-based model.
module tb_mux4_rr_arbiter;

  localparam int unsigned MAXH = 8;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_req;
  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_valid;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the mux, who was granted last, how long the owner has held it.
  int m_owner = -1;
  int m_last  = 3;
  int m_held  = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_req  (i_req),
    .o_gnt  (o_gnt),
    .o_sel  (o_sel),
    .o_valid(o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic int pick(input int vec, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (((vec >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input int req, input bit rst);
    int others;
    int w;
    if (rst) begin
      m_owner = -1; m_last = 3; m_held = 0;
    end else if (m_owner < 0) begin
      w = pick(req, m_last);
      if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
    end else begin
      others = req & ~(1 << m_owner);
      if (((req >> m_owner) & 1) == 0) begin
        w = pick(others, m_last);
        if (w >= 0) begin m_owner = w; m_last = w; m_held = 1; end
        else begin m_owner = -1; m_held = 0; end
      end else if (m_held >= int'(MAXH) && others != 0) begin
        w = pick(others, m_last);
        m_owner = w; m_last = w; m_held = 1;
      end else if (m_held < int'(MAXH)) begin
        m_held++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, let the model take the edge, compare #1 after it.
  task automatic step(input logic [3:0] req, input bit rst);
    logic [3:0] eg;
    logic [1:0] es;
    @(negedge i_clk);
    i_req = req;
    i_rst = rst;
    @(posedge i_clk);
    model_edge(int'(req), rst);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    es = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    chk("model_gnt", o_gnt, eg);
    chk("model_sel", {2'b00, o_sel}, {2'b00, es});
    chk("model_valid", {3'b000, o_valid}, {3'b000, (m_owner >= 0)});
  endtask

  initial begin
    logic [3:0] r;
    i_req = '0;
    i_rst = 1'b1;

    // Reset state
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("rst_gnt", o_gnt, 4'b0000);
    chk("rst_valid", {3'b000, o_valid}, 4'd0);

    // First grant after reset, then release to idle
    step(4'b0001, 1'b0);
    chk("first_gnt", o_gnt, 4'b0001);
    chk("first_sel", {2'b00, o_sel}, 4'd0);
    chk("first_valid", {3'b000, o_valid}, 4'd1);
    step(4'b0000, 1'b0);
    chk("release_gnt", o_gnt, 4'b0000);
    chk("release_valid", {3'b000, o_valid}, 4'd0);

    // Full contention from reset: 0,1,2,3,0 each exactly MAXH cycles
    step(4'b0000, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      step(4'b1111, 1'b0);
      chk("contention_sel", {2'b00, o_sel}, 4'(((i - 1) / MAXH) % 4));
    end

    // Early release while requester 2 owns
    for (int i = 0; i < 40 && o_sel != 2'd2; i++) step(4'b1111, 1'b0);
    chk("reach_owner2", {2'b00, o_sel}, 4'd2);
    step(4'b1011, 1'b0);
    chk("early_rel_gnt", o_gnt, 4'b1000);
    chk("early_rel_sel", {2'b00, o_sel}, 4'd3);
    for (int i = 0; i < int'(MAXH) - 1; i++) begin
      step(4'b1011, 1'b0);
      chk("early_rel_hold", o_gnt, 4'b1000);
    end
    step(4'b1011, 1'b0);
    chk("early_rel_preempt", o_gnt, 4'b0001);
    step(4'b0011, 1'b0);
    chk("after_rel_gnt", o_gnt, 4'b0001);

    // Lone requester keeps grant, then is preempted at once when bit 0 joins
    for (int i = 0; i < 50; i++) begin
      step(4'b0100, 1'b0);
      chk("lone_gnt", o_gnt, 4'b0100);
    end
    step(4'b0101, 1'b0);
    chk("lone_preempt_gnt", o_gnt, 4'b0001);

    // Reset mid-operation while requester 1 owns
    for (int i = 0; i < 40 && o_sel != 2'd1; i++) step(4'b1111, 1'b0);
    chk("reach_owner1", {2'b00, o_sel}, 4'd1);
    step(4'b1111, 1'b1);
    chk("midrst_gnt", o_gnt, 4'b0000);
    chk("midrst_valid", {3'b000, o_valid}, 4'd0);
    step(4'b1111, 1'b0);
    chk("postrst_gnt", o_gnt, 4'b0001);

    // Owner 3 drops while bit 1 rises in the same cycle
    step(4'b1000, 1'b0);
    chk("owner3_gnt", o_gnt, 4'b1000);
    step(4'b0010, 1'b0);
    chk("swap_gnt", o_gnt, 4'b0010);
    chk("swap_valid", {3'b000, o_valid}, 4'd1);

    // Randomized traffic with sticky requests and occasional reset
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
